// File: rtl/parking_gate_arbiter.sv
// Shared-lane gate arbiter: opens one direction at a time, closes on passage or timeout.
// Define PARKING_EXIT_PRIORITY_EN to make exit win every simultaneous request.
module parking_gate_arbiter #(
  parameter int unsigned CNT_W          = 5,
  parameter int unsigned CAPACITY       = 25,
  parameter int unsigned TIMEOUT_CYCLES = 250,
  parameter int unsigned CLOSE_CYCLES   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enter_req,
  input  logic             exit_req,
  input  logic             entered,
  input  logic             exited,
  input  logic [CNT_W-1:0] occupancy,
  output logic             gate_in_open,
  output logic             gate_out_open,
  output logic             lot_full,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned TimerMax = (TIMEOUT_CYCLES > CLOSE_CYCLES) ? TIMEOUT_CYCLES
                                                                      : CLOSE_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);
  localparam int unsigned CapW     = CNT_W + 1;

  localparam logic [TimerW-1:0] OpenLast  = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0] CloseLast = TimerW'(CLOSE_CYCLES - 1);
  localparam logic [CapW-1:0]   Capacity  = CapW'(CAPACITY);

  typedef enum logic [1:0] {StIdle, StInOpen, StOutOpen, StClosing} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                last_exit_q, last_exit_d;
  logic                timeout_d;
  logic                elig_in, elig_out, tie_exit;

  assign lot_full = ({1'b0, occupancy} >= Capacity);
  assign elig_in  = enter_req & ~lot_full;
  assign elig_out = exit_req & (occupancy != '0);

`ifdef PARKING_EXIT_PRIORITY_EN
  assign tie_exit = 1'b1;
`else
  assign tie_exit = ~last_exit_q;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_exit_d = last_exit_q;
    timeout_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (elig_in || elig_out) begin
          last_exit_d = elig_out & (~elig_in | tie_exit);
          state_d     = last_exit_d ? StOutOpen : StInOpen;
          timer_d     = '0;
        end
      end
      StInOpen, StOutOpen: begin
        // Passage beats a timeout expiring on the same cycle.
        if ((state_q == StInOpen && entered) || (state_q == StOutOpen && exited)) begin
          state_d = StClosing;
          timer_d = '0;
        end else if (timer_q == OpenLast) begin
          state_d   = StClosing;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StClosing: begin
        if (timer_q == CloseLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        timer_d = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so gates move one cycle after sampling.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      last_exit_q   <= 1'b1;
      gate_in_open  <= 1'b0;
      gate_out_open <= 1'b0;
      busy          <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      last_exit_q   <= last_exit_d;
      gate_in_open  <= (state_d == StInOpen);
      gate_out_open <= (state_d == StOutOpen);
      busy          <= (state_d != StIdle);
      timeout       <= timeout_d;
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios plus random traffic against a
// phase/age reference model; honours PARKING_EXIT_PRIORITY_EN.
module tb_parking_gate_arbiter;

  localparam int CAP = 25;
  localparam int TO  = 250;
  localparam int CL  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter_req, exit_req, entered, exited;
  logic [4:0] occupancy;
  logic       gate_in_open, gate_out_open, lot_full, busy, timeout;
  logic [4:0] dut_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 entry open, 2 exit open, 3 closing.
  int m_phase;
  int m_age;
  bit m_last_exit;
  bit m_timeout;

  parking_gate_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .enter_req    (enter_req),
    .exit_req     (exit_req),
    .entered      (entered),
    .exited       (exited),
    .occupancy    (occupancy),
    .gate_in_open (gate_in_open),
    .gate_out_open(gate_out_open),
    .lot_full     (lot_full),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  assign dut_vec = {gate_in_open, gate_out_open, lot_full, busy, timeout};

  always @(negedge clk) begin
    if (gate_in_open && gate_out_open) begin
      errors = errors + 1;
      $display("FAIL gate_exclusive: both gates open at %0t", $time);
    end
  end

  function automatic logic [4:0] exp_vec();
    return {m_phase == 1, m_phase == 2, int'(occupancy) >= CAP, m_phase != 0, m_timeout};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_age = 0; m_last_exit = 1'b1; m_timeout = 1'b0;
  endtask

  task automatic model_step();
    bit ein, eout;
    m_timeout = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        ein  = enter_req && (int'(occupancy) < CAP);
        eout = exit_req && (occupancy != 0);
        if (ein && eout) begin
`ifdef PARKING_EXIT_PRIORITY_EN
          m_phase = 2;
`else
          m_phase = m_last_exit ? 1 : 2;
`endif
        end else if (ein) m_phase = 1;
        else if (eout) m_phase = 2;
        if (m_phase != 0) m_last_exit = (m_phase == 2);
        m_age = 0;
      end
      1, 2: begin
        m_age++;
        if ((m_phase == 1 && entered) || (m_phase == 2 && exited)) begin
          m_phase = 3; m_age = 0;
        end else if (m_age == TO) begin
          m_phase = 3; m_age = 0; m_timeout = 1'b1;
        end
      end
      default: begin
        m_age++;
        if (m_age == CL) begin m_phase = 0; m_age = 0; end
      end
    endcase
  endtask

  // One clock: model consumes the inputs the DUT samples, outputs read 1 time unit later.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    entered = 1'b0;
    exited  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; enter_req = 0; exit_req = 0; entered = 0; exited = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enter_req = 0; exit_req = 0; entered = 0; exited = 0; occupancy = '0;
    model_reset();
    #1;
    checks++;
    if (dut_vec !== 5'b00000) begin
      errors++; $display("FAIL reset_state: got %b expected 00000", dut_vec);
    end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_entry();
    int closed;
    do_reset();
    occupancy = 5'd3; enter_req = 1'b1;
    tick();
    checks++;
    if (gate_in_open !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL entry_latency: got in=%b busy=%b expected 1 1", gate_in_open, busy);
    end
    enter_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) entered = 1'b1;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL entry_open[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (gate_in_open !== 1'b0) begin
      errors++; $display("FAIL entry_close: got gate_in_open=%b expected 0", gate_in_open);
    end
    closed = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (gate_in_open || gate_out_open) break;
      closed++;
      tick();
    end
    checks++;
    if (closed != CL || busy !== 1'b0) begin
      errors++; $display("FAIL closing_guard: got %0d cycles busy=%b expected %0d busy=0",
                         closed, busy, CL);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_dir;
    logic       dir;
`ifdef PARKING_EXIT_PRIORITY_EN
    exp_dir = 4'b1111;
`else
    exp_dir = 4'b1010;
`endif
    do_reset();
    occupancy = 5'd10; enter_req = 1'b1; exit_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      int waited;
      waited = 0;
      while (!gate_in_open && !gate_out_open && waited < 30) begin
        tick();
        waited++;
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL rr_wait[%0d]: got %b expected %b", g, dut_vec, exp_vec());
        end
      end
      dir = gate_out_open;
      checks++;
      if (waited >= 30 || dir !== exp_dir[g]) begin
        errors++; $display("FAIL rr_grant[%0d]: got out=%b waited=%0d expected out=%b",
                           g, dir, waited, exp_dir[g]);
      end
      entered = gate_in_open;
      exited  = gate_out_open;
      tick();
    end
    enter_req = 1'b0; exit_req = 1'b0;
  endtask

  task automatic test_lot_full();
    do_reset();
    occupancy = 5'd25; enter_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (dut_vec !== 5'b00100 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL lot_full[%0d]: got %b expected 00100", i, dut_vec);
      end
    end
    exit_req = 1'b1;
    tick();
    checks++;
    if (gate_out_open !== 1'b1 || gate_in_open !== 1'b0) begin
      errors++; $display("FAIL full_exit_grant: got in=%b out=%b expected 0 1",
                         gate_in_open, gate_out_open);
    end
    exit_req = 1'b0; enter_req = 1'b0;
  endtask

  task automatic test_timeout();
    int open_cnt;
    int pulses;
    do_reset();
    occupancy = '0; exit_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (dut_vec !== 5'b00000) begin
        errors++; $display("FAIL empty_exit[%0d]: got %b expected 00000", i, dut_vec);
      end
    end
    exit_req = 1'b0; enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    open_cnt = 0;
    pulses = 0;
    while (gate_in_open && open_cnt < 400) begin
      if (timeout) pulses++;
      open_cnt++;
      tick();
    end
    checks++;
    if (open_cnt != TO || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_close: got open=%0d timeout=%b expected %0d 1",
                         open_cnt, timeout, TO);
    end
    for (int i = 0; i < 12; i++) begin
      if (timeout) pulses++;
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL timeout_pulse: got %0d pulse cycles expected 1", pulses);
    end
  endtask

  task automatic test_passage_vs_timeout();
    do_reset();
    occupancy = 5'd5; enter_req = 1'b1;
    tick();
    enter_req = 1'b0;
    for (int i = 1; i < TO; i++) tick();
    checks++;
    if (gate_in_open !== 1'b1) begin
      errors++; $display("FAIL open_at_limit: got gate_in_open=%b expected 1", gate_in_open);
    end
    entered = 1'b1;
    tick();
    checks++;
    if (dut_vec !== 5'b00010 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL passage_wins: got %b expected 00010", dut_vec);
    end
  endtask

  task automatic test_async_reset_mid();
    do_reset();
    occupancy = 5'd3; enter_req = 1'b1;
    tick();
    checks++;
    if (gate_in_open !== 1'b1) begin
      errors++; $display("FAIL pre_reset_open: got %b expected 1", gate_in_open);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gate_in_open !== 1'b0 || gate_out_open !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL async_reset: got in=%b out=%b busy=%b expected 0 0 0",
                         gate_in_open, gate_out_open, busy);
    end
    @(posedge clk);
    #1;
    enter_req = 1'b0;
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL post_reset_idle: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    occupancy = 5'd12;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) enter_req = 1'($urandom);
      if ($urandom_range(0, 3) == 0) exit_req = 1'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       occupancy = '0;
          1:       occupancy = 5'(CAP - 1 + $urandom_range(0, 1));
          default: occupancy = 5'($urandom_range(0, 31));
        endcase
      end
      entered = ($urandom_range(0, 9) == 0);
      exited  = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %b expected %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_entry();
    test_round_robin();
    test_lot_full();
    test_timeout();
    test_passage_vs_timeout();
    test_async_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
